stream_pattern_ctrl: RTL and testbench
======================================

// Module: stream_pattern_ctrl
// PURPOSE
//   Sequences a programmable serial pattern detector over a stream of parallel words.
//   Accepts WORD_W-bit words on a valid/ready input and shifts each word MSB-first, one bit per cycle, into the detector.
//   Counts pattern hits per word and returns the count on a valid/ready output.
//   Sits between a parallel producer and any consumer of per-word match counts.
// PARAMETERS
//   WORD_W  8  bits per input word (>=2)
//   PAT_W   4  pattern length in bits (2..WORD_W)
//   CNT_W   4  width of the per-word hit count; saturates at 2**CNT_W-1
// PORTS
//   clk          in   1       system clock, rising edge
//   n_rst        in   1       asynchronous active-low reset
//   cfg_pattern  in   PAT_W   pattern; MSB = first bit in time; sampled on cfg_load
//   cfg_load     in   1       load cfg_pattern and clear history; honoured in IDLE only
//   in_valid     in   1       input word valid
//   in_data      in   WORD_W  input word
//   in_ready     out  1       block can accept a word (high only in IDLE)
//   out_valid    out  1       out_count valid
//   out_count    out  CNT_W   hits detected while shifting the last word
//   out_ready    in   1       consumer accepts out_count
//   busy         out  1       state != IDLE
// BEHAVIOUR
//   Clock and reset:
//   - Single clock domain.
//   - The asynchronous active-low reset n_rst forces the following register values:
//     - state=IDLE
//     - pattern register=0
//     - history and fill count cleared
//     - out_valid=0, out_count=0, busy=0
//     - in_ready=1, since it is decoded from IDLE
//   FSM states: IDLE, SHIFT, REPORT.
//   IDLE:
//   - in_ready=1.
//   - Accept occurs on in_valid&in_ready: latch in_data, bit index=WORD_W-1, hit counter=0, next state SHIFT.
//   - cfg_load in IDLE: pattern<=cfg_pattern; history and fill count cleared.
//     - If cfg_load and in_valid are both high, both take effect.
//     - The new word is then matched against the new pattern with empty history.
//   SHIFT:
//   - Each cycle, the bit at the current index is pushed into the detector.
//   - Hit when fill>=PAT_W-1 and {history[PAT_W-2:0], bit} == pattern.
//     - A hit increments the counter, saturating at 2**CNT_W-1.
//   - Matches may overlap.
//   - History persists across words, so matches may span word boundaries.
//   - Fill count saturates at PAT_W-1.
//   - After the bit at index 0 is pushed, next state is REPORT.
//   - cfg_load and in_valid are ignored.
//   REPORT:
//   - out_valid=1, with out_count holding the final count.
//   - Both stay stable while out_ready=0.
//   - out_valid&out_ready moves the block to IDLE with out_valid=0 the next cycle.
//   Latency:
//   - Accept edge T.
//   - Shifts occur on edges T+1..T+WORD_W.
//   - out_valid=1 from edge T+WORD_W.
//   - With out_ready held high, the next word is accepted at edge T+WORD_W+2 at the earliest.
//   Reset mid-operation:
//   - The word in flight is discarded and no output is produced.
//   - The pattern must be reloaded after reset.
// CONFIGURATION
//   STREAM_PATTERN_MASK_EN defined:
//   - Adds input cfg_mask[PAT_W], latched with cfg_pattern on cfg_load; reset value all ones.
//   - A pattern bit whose mask bit is 0 is don't-care.
//   - Hit when (({history,bit} ^ pattern) & mask) == 0, subject to the same fill rule.
//   STREAM_PATTERN_MASK_EN undefined:
//   - No cfg_mask port; exact compare.
// STRUCTURE
//   Package stream_pattern_pkg:
//   - state_t enum {IDLE, SHIFT, REPORT}
//   - localparams for default WORD_W/PAT_W/CNT_W
//   Sub-module pattern_match_fsm (instanced once):
//   - Contents: pattern/mask registers, PAT_W-1 bit history, fill counter, combinational hit output.
//   - Inputs: clk, n_rst, load, pattern, bit_valid, bit_in.
//   Top level holds the sequencing FSM, word register, bit index, hit counter and handshakes.
// TESTING
//   1 load 4'b1101, send 8'b1101_1010 -> out_count=2, out_valid at 8 edges after accept
//   2 load 4'b1101, words 8'b0000_0011 then 8'b0100_0000 -> counts 0 then 1 (cross-word hit)
//   3 repeat 2 with cfg_load pulse in IDLE between words -> counts 0 then 0
//     cfg_load pulsed mid-SHIFT -> ignored, counts unchanged
//   4 out_ready=0 for 5 cycles in REPORT -> out_valid/out_count stable, in_ready=0, busy=1
//     in_valid during this time -> not accepted
//   5 n_rst low at 3rd SHIFT cycle -> out_valid=0, busy=0, in_ready=1
//     after reload, next word counted from empty history
//   6 CNT_W=2, load 4'b0000, send 8'h00 from reset -> 5 hits saturate, out_count=2'd3

Source files
------------

// File: rtl/stream_pattern_pkg.sv
// Shared types and default sizes for the stream pattern controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Optional feature macro: STREAM_PATTERN_MASK_EN.
package stream_pattern_pkg;

    localparam int DEF_WORD_W = 8;
    localparam int DEF_PAT_W  = 4;
    localparam int DEF_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

endpackage

// File: rtl/pattern_match_fsm.sv
// Serial pattern detector: pattern/mask registers, bit history, fill counter.
// Latency: hit is combinational on the bit being pushed; history updates on the same edge.
// Backpressure: none; a bit is consumed on every cycle with bit_valid high. Macro: STREAM_PATTERN_MASK_EN.
module pattern_match_fsm
    import stream_pattern_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W
)
(
    input  logic             clk,
    input  logic             n_rst,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern,
`ifdef STREAM_PATTERN_MASK_EN
    input  logic [PAT_W-1:0] mask,
`endif
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             hit
);

    localparam int FILL_W = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [PAT_W-1:0]  pat_q;
    logic [PAT_W-2:0]  hist_q;
    logic [FILL_W-1:0] fill_q;
    logic [PAT_W-1:0]  window;
    logic              match;

    // The candidate window is the stored history with the incoming bit appended as LSB.
    assign window = {hist_q, bit_in};

`ifdef STREAM_PATTERN_MASK_EN
    logic [PAT_W-1:0] mask_q;

    // Mask register; all ones after reset so the compare starts out exact.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)    mask_q <= '1;
        else if (load) mask_q <= mask;
    end

    assign match = ((window ^ pat_q) & mask_q) == '0;
`else
    assign match = (window == pat_q);
`endif

    // Only report a hit once the history holds PAT_W-1 real bits.
    assign hit = bit_valid && (fill_q == FILL_MAX) && match;

    // Pattern load clears history; otherwise each pushed bit shifts in and fill saturates.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pat_q  <= '0;
            hist_q <= '0;
            fill_q <= '0;
        end else if (load) begin
            pat_q  <= pattern;
            hist_q <= '0;
            fill_q <= '0;
        end else if (bit_valid) begin
            hist_q <= window[PAT_W-2:0];
            if (fill_q != FILL_MAX) fill_q <= fill_q + 1'b1;
        end
    end

endmodule

// File: rtl/stream_pattern_ctrl.sv
// Shifts accepted words MSB-first into a pattern detector and reports per-word hit counts.
// Latency: out_valid rises WORD_W edges after the accept edge; next accept at +WORD_W+2 earliest.
// Backpressure: in_ready only in IDLE; REPORT holds out_valid/out_count until out_ready. Macro: STREAM_PATTERN_MASK_EN.
module stream_pattern_ctrl
    import stream_pattern_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int PAT_W  = DEF_PAT_W,
    parameter int CNT_W  = DEF_CNT_W
)
(
    input  logic              clk,
    input  logic              n_rst,
    input  logic [PAT_W-1:0]  cfg_pattern,
`ifdef STREAM_PATTERN_MASK_EN
    input  logic [PAT_W-1:0]  cfg_mask,
`endif
    input  logic              cfg_load,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [CNT_W-1:0]  out_count,
    input  logic              out_ready,
    output logic              busy
);

    localparam int IDX_W = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state_q;
    state_t            state_d;
    logic [WORD_W-1:0] word_q;
    logic [IDX_W-1:0]  idx_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              accept;
    logic              shift_en;
    logic              load_en;
    logic              hit;

    assign accept    = in_valid && in_ready;
    assign shift_en  = (state_q == SHIFT);
    // Config loads are only honoured between words so a word never sees two patterns.
    assign load_en   = cfg_load && in_ready;
    assign out_count = cnt_q;

    pattern_match_fsm #(
        .PAT_W(PAT_W)
    ) u_match (
        .clk       (clk),
        .n_rst     (n_rst),
        .load      (load_en),
        .pattern   (cfg_pattern),
`ifdef STREAM_PATTERN_MASK_EN
        .mask      (cfg_mask),
`endif
        .bit_valid (shift_en),
        .bit_in    (word_q[idx_q]),
        .hit       (hit)
    );

    // Sequencing state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and handshake outputs, all decoded from the current state.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_d = SHIFT;
            end
            SHIFT: begin
                if (idx_q == '0) state_d = REPORT;
            end
            REPORT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Word capture, MSB-first bit index and saturating hit counter.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            word_q <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
        end else if (accept) begin
            word_q <= in_data;
            idx_q  <= IDX_W'(WORD_W - 1);
            cnt_q  <= '0;
        end else if (shift_en) begin
            if (idx_q != '0) idx_q <= idx_q - 1'b1;
            if (hit && (cnt_q != CNT_MAX)) cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_stream_pattern_ctrl.sv
// Directed and randomized bench for stream_pattern_ctrl against a bit-stream reference model.
// Latency: checks accept-to-out_valid spacing and earliest re-accept.
// Backpressure: exercises out_ready stalls with in_valid held high. Macro: STREAM_PATTERN_MASK_EN.
module tb_stream_pattern_ctrl;

    logic       clk;
    logic       n_rst;
    logic [3:0] cfg_pattern;
    logic       cfg_load;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_count;
    logic       out_ready;
    logic       busy;

    logic [3:0] s_cfg_pattern;
    logic       s_cfg_load;
    logic       s_in_valid;
    logic [7:0] s_in_data;
    logic       s_in_ready;
    logic       s_out_valid;
    logic [1:0] s_out_count;
    logic       s_out_ready;
    logic       s_busy;

`ifdef STREAM_PATTERN_MASK_EN
    logic [3:0] cfg_mask;
    logic [3:0] s_cfg_mask;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: the raw bit stream since the last load/reset, plus pattern and mask.
    bit         mhist[$];
    logic [3:0] mpat;
    logic [3:0] mmask;

    stream_pattern_ctrl #(.WORD_W(8), .PAT_W(4), .CNT_W(4)) dut (
        .clk(clk), .n_rst(n_rst), .cfg_pattern(cfg_pattern),
`ifdef STREAM_PATTERN_MASK_EN
        .cfg_mask(cfg_mask),
`endif
        .cfg_load(cfg_load), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_count(out_count),
        .out_ready(out_ready), .busy(busy)
    );

    stream_pattern_ctrl #(.WORD_W(8), .PAT_W(4), .CNT_W(2)) dut_sat (
        .clk(clk), .n_rst(n_rst), .cfg_pattern(s_cfg_pattern),
`ifdef STREAM_PATTERN_MASK_EN
        .cfg_mask(s_cfg_mask),
`endif
        .cfg_load(s_cfg_load), .in_valid(s_in_valid), .in_data(s_in_data),
        .in_ready(s_in_ready), .out_valid(s_out_valid), .out_count(s_out_count),
        .out_ready(s_out_ready), .busy(s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count hits of the last 4 stream bits against the pattern after each appended bit.
    function automatic int model_word(input logic [7:0] w, input int cw);
        int c;
        logic [3:0] win;
        c = 0;
        for (int i = 7; i >= 0; i--) begin
            mhist.push_back(w[i]);
            if (mhist.size() > 4) void'(mhist.pop_front());
            if (mhist.size() == 4) begin
                for (int k = 0; k < 4; k++) win[3-k] = mhist[k];
                if (((win ^ mpat) & mmask) == 4'd0) c++;
            end
        end
        if (c > (1 << cw) - 1) c = (1 << cw) - 1;
        return c;
    endfunction

    task automatic load_pattern(input logic [3:0] p, input logic [3:0] m);
        cfg_pattern = p;
`ifdef STREAM_PATTERN_MASK_EN
        cfg_mask = m;
        mmask    = m;
`else
        mmask    = 4'hF;
`endif
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        mpat = p;
        mhist.delete();
    endtask

    // Send one word, check latency/count, optionally stall REPORT and pulse cfg_load mid-SHIFT.
    task automatic run_word(input string tag, input logic [7:0] w, input int stall, input bit mid_load);
        int exp;
        int n;
        exp = model_word(w, 4);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
        in_data  = $urandom();
        check({tag, ".busy_after_accept"}, 32'(busy), 32'd1);
        n = 0;
        while (!out_valid && n < 40) begin
            if (mid_load && n == 2) begin
                cfg_pattern = ~mpat;
                cfg_load    = 1'b1;
            end
            tick();
            cfg_load    = 1'b0;
            cfg_pattern = mpat;
            n++;
        end
        check({tag, ".latency"}, 32'(n), 32'd8);
        check({tag, ".count"}, 32'(out_count), 32'(exp));
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            in_data  = $urandom();
            tick();
            check({tag, ".stall_valid"}, 32'(out_valid), 32'd1);
            check({tag, ".stall_count"}, 32'(out_count), 32'(exp));
            check({tag, ".stall_in_ready"}, 32'(in_ready), 32'd0);
            check({tag, ".stall_busy"}, 32'(busy), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".done_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".done_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        n_rst = 1'b0;
        cfg_pattern = 4'd0; cfg_load = 1'b0; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
        s_cfg_pattern = 4'd0; s_cfg_load = 1'b0; s_in_valid = 1'b0; s_in_data = 8'd0; s_out_ready = 1'b0;
`ifdef STREAM_PATTERN_MASK_EN
        cfg_mask = 4'hF; s_cfg_mask = 4'hF;
`endif
        mpat = 4'd0; mmask = 4'hF;
        tick(); tick();
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.out_count", 32'(out_count), 32'd0);
        n_rst = 1'b1;
        tick();

        // Saturation: reset pattern 0000 against an all-zero word gives 5 hits into a 2-bit counter.
        s_in_valid = 1'b1;
        s_in_data  = 8'h00;
        tick();
        s_in_valid = 1'b0;
        n = 0;
        while (!s_out_valid && n < 40) begin tick(); n++; end
        check("sat.latency", 32'(n), 32'd8);
        check("sat.count", 32'(s_out_count), 32'd3);
        s_out_ready = 1'b1;
        tick();
        s_out_ready = 1'b0;
        check("sat.done_busy", 32'(s_busy), 32'd0);

        // Basic word with two overlapping-capable hits.
        load_pattern(4'b1101, 4'hF);
        run_word("t1", 8'b1101_1010, 0, 1'b0);

        // Match spanning a word boundary.
        load_pattern(4'b1101, 4'hF);
        run_word("t2a", 8'b0000_0011, 0, 1'b0);
        run_word("t2b", 8'b0100_0000, 0, 1'b0);

        // Reload between words kills the cross-word hit; mid-SHIFT load is ignored.
        load_pattern(4'b1101, 4'hF);
        run_word("t3a", 8'b0000_0011, 0, 1'b1);
        load_pattern(4'b1101, 4'hF);
        run_word("t3b", 8'b0100_0000, 0, 1'b1);

        // REPORT stall with in_valid asserted throughout.
        run_word("t4", 8'b1101_1101, 5, 1'b0);

        // Back-to-back with out_ready held high: re-accept no earlier than WORD_W+2 edges.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        void'(model_word(8'hA5, 4));
        tick();
        n = 0;
        while (!(in_ready && n > 0) && n < 40) begin tick(); n++; end
        check("b2b.reaccept_gap", 32'(n + 1), 32'd10);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();

        // Reset during the third SHIFT cycle discards the word.
        load_pattern(4'b1101, 4'hF);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        n_rst = 1'b0;
        #1;
        check("t5.out_valid", 32'(out_valid), 32'd0);
        check("t5.busy", 32'(busy), 32'd0);
        check("t5.in_ready", 32'(in_ready), 32'd1);
        tick();
        n_rst = 1'b1;
        tick();
        mhist.delete();
        load_pattern(4'b1101, 4'hF);
        run_word("t5.after", 8'b1011_0110, 0, 1'b0);

        // Randomized words, patterns and stalls against the stream model.
        for (int r = 0; r < 24; r++) begin
            if ($urandom_range(0, 3) == 0)
                load_pattern(4'($urandom()), 4'($urandom()) | 4'b1000);
            run_word($sformatf("rnd%0d", r), 8'($urandom()), int'($urandom_range(0, 3)), 1'($urandom()));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
